// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
//   Shares the single data-memory port between speculative load issue and
//   committed store drain. Loads win by default; a store wins once it has
//   waited STORE_MAX_WAIT cycles, or when the load reads the store's word.
//   One load may be in flight; a mispredict that makes it wrong-path
//   suppresses its writeback, while the port stays busy until the read data
//   returns.
//
// Ports
//   clk, reset                   clock, asynchronous active-high reset
//   ld_valid/ready/addr/func3/pd/rob   load request from the memory FU
//   st_valid/ready/addr/data/func3     head store drain from the LSQ
//   rob_head                     current ROB head tag (age reference)
//   mispredict, mispredict_tag   flush pulse and offending branch tag
//   mem_req/we/addr/wdata/func3  memory port request
//   mem_rvalid, mem_rdata        memory read response
//   ld_done, ld_done_pd/rob/data load writeback
//   busy                         a load is in flight
module dmem_port_arbiter #(
    parameter int ROB_DEPTH      = 16,
    parameter int TAG_W          = 5,
    parameter int PD_W           = 7,
    parameter int STORE_MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [2:0]       ld_func3,
    input  logic [PD_W-1:0]  ld_pd,
    input  logic [TAG_W-1:0] ld_rob,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [2:0]       st_func3,
    input  logic [TAG_W-1:0] rob_head,
    input  logic             mispredict,
    input  logic [TAG_W-1:0] mispredict_tag,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [2:0]       mem_func3,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             ld_done,
    output logic [PD_W-1:0]  ld_done_pd,
    output logic [TAG_W-1:0] ld_done_rob,
    output logic [31:0]      ld_done_data,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, LD_WAIT = 1'b1} state_e;

    localparam int               WC_W    = $clog2(STORE_MAX_WAIT + 1);
    localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(STORE_MAX_WAIT);
    localparam logic [TAG_W:0]   DEPTH_L = (TAG_W + 1)'(ROB_DEPTH);

    state_e            state_q, state_d;
    logic              killed_q, killed_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [PD_W-1:0]   pd_q, pd_d;
    logic [TAG_W-1:0]  rob_q, rob_d;

    logic              blocked, st_win, ld_win, kill_now;
    logic [TAG_W:0]    d_ld, d_br;

    // Distance of a tag from the ROB head, modulo ROB_DEPTH. One extra bit
    // keeps tag + ROB_DEPTH from overflowing before the wrap correction.
    function automatic logic [TAG_W:0] rob_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] head);
        logic [TAG_W:0] t;
        t = {1'b0, tag} + DEPTH_L - {1'b0, head};
        if (t >= DEPTH_L) t = t - DEPTH_L;
        return t;
    endfunction

    assign d_ld = rob_age(rob_q, rob_head);
    assign d_br = rob_age(mispredict_tag, rob_head);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            killed_q   <= 1'b0;
            wait_cnt_q <= '0;
            pd_q       <= '0;
            rob_q      <= '0;
        end else begin
            state_q    <= state_d;
            killed_q   <= killed_d;
            wait_cnt_q <= wait_cnt_d;
            pd_q       <= pd_d;
            rob_q      <= rob_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        killed_d     = killed_q;
        pd_d         = pd_q;
        rob_d        = rob_q;
        wait_cnt_d   = wait_cnt_q;
        ld_ready     = 1'b0;
        st_ready     = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_func3    = '0;
        ld_done      = 1'b0;
        ld_done_pd   = '0;
        ld_done_rob  = '0;
        ld_done_data = '0;
        busy         = 1'b0;
        kill_now     = 1'b0;

        // Same-word conflict: the load must not bypass the older store.
        blocked = st_valid && ld_valid && (st_addr[31:2] == ld_addr[31:2]);
        st_win  = st_valid && (!ld_valid || blocked || (wait_cnt_q >= WC_MAX));
        ld_win  = !st_win && ld_valid && !mispredict;

        case (state_q)
            IDLE: begin
                // Grants are combinational, so hold them off while reset is up.
                if (!reset) begin
                    if (st_win) begin
                        st_ready  = 1'b1;
                        mem_req   = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = st_addr;
                        mem_wdata = st_data;
                        mem_func3 = st_func3;
                    end else if (ld_win) begin
                        ld_ready  = 1'b1;
                        mem_req   = 1'b1;
                        mem_addr  = ld_addr;
                        mem_func3 = ld_func3;
                        pd_d      = ld_pd;
                        rob_d     = ld_rob;
                        killed_d  = 1'b0;
                        state_d   = LD_WAIT;
                    end
                end
            end
            LD_WAIT: begin
                busy = 1'b1;
                // Load strictly younger than the branch is on the wrong path.
                kill_now = mispredict && (d_ld > d_br);
                if (kill_now) killed_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = IDLE;
                    if (!killed_q && !kill_now) begin
                        ld_done      = 1'b1;
                        ld_done_pd   = pd_q;
                        ld_done_rob  = rob_q;
                        ld_done_data = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Store aging counts every cycle the head store is left waiting.
        if (!st_valid || st_ready)  wait_cnt_d = '0;
        else if (wait_cnt_q < WC_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
    localparam int ROB_DEPTH = 16;
    localparam int TAG_W = 5;
    localparam int PD_W = 7;
    localparam int MAXW = 4;

    logic clk = 1'b0;
    logic reset;
    logic ld_valid, ld_ready, st_valid, st_ready;
    logic [31:0] ld_addr, st_addr, st_data, mem_addr, mem_wdata, mem_rdata, ld_done_data;
    logic [2:0] ld_func3, st_func3, mem_func3;
    logic [PD_W-1:0] ld_pd, ld_done_pd;
    logic [TAG_W-1:0] ld_rob, rob_head, mispredict_tag, ld_done_rob;
    logic mispredict, mem_req, mem_we, mem_rvalid, ld_done, busy;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    bit m_busy, m_killed;
    int m_pd, m_rob, m_wc;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W), .PD_W(PD_W),
                        .STORE_MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_func3(ld_func3), .ld_pd(ld_pd), .ld_rob(ld_rob),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_data(st_data), .st_func3(st_func3),
        .rob_head(rob_head), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_func3(mem_func3),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .ld_done(ld_done), .ld_done_pd(ld_done_pd), .ld_done_rob(ld_done_rob),
        .ld_done_data(ld_done_data), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int age(input int tag, input int head);
        return (tag - head + ROB_DEPTH) % ROB_DEPTH;
    endfunction

    // Compare every output against the model for the current inputs, then
    // advance the model across the next rising edge.
    task automatic tick();
        bit e_ldr, e_str, e_done, e_busy, st_w, ld_w, young;
        logic [31:0] e_addr, e_wd, e_f3, e_pd, e_rob, e_data;
        e_ldr = 0; e_str = 0; e_done = 0; e_busy = 0;
        e_addr = 0; e_wd = 0; e_f3 = 0; e_pd = 0; e_rob = 0; e_data = 0;
        st_w = 0; ld_w = 0; young = 0;
        #2;
        if (!reset) begin
            if (!m_busy) begin
                st_w = st_valid && (!ld_valid || m_wc >= MAXW ||
                       (ld_valid && (st_addr >> 2) == (ld_addr >> 2)));
                ld_w = !st_w && ld_valid && !mispredict;
                if (st_w) begin
                    e_str = 1; e_addr = st_addr; e_wd = st_data; e_f3 = {29'b0, st_func3};
                end else if (ld_w) begin
                    e_ldr = 1; e_addr = ld_addr; e_f3 = {29'b0, ld_func3};
                end
            end else begin
                e_busy = 1;
                young = mispredict && age(m_rob, rob_head) > age(mispredict_tag, rob_head);
                if (mem_rvalid && !m_killed && !young) begin
                    e_done = 1; e_pd = m_pd; e_rob = m_rob; e_data = mem_rdata;
                end
            end
        end
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, e_ldr});
        chk("st_ready", {31'b0, st_ready}, {31'b0, e_str});
        chk("mem_req", {31'b0, mem_req}, {31'b0, e_ldr | e_str});
        chk("mem_we", {31'b0, mem_we}, {31'b0, e_str});
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_func3", {29'b0, mem_func3}, e_f3);
        chk("ld_done", {31'b0, ld_done}, {31'b0, e_done});
        chk("ld_done_pd", {25'b0, ld_done_pd}, e_pd);
        chk("ld_done_rob", {27'b0, ld_done_rob}, e_rob);
        chk("ld_done_data", ld_done_data, e_data);
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_killed = 0; m_pd = 0; m_rob = 0; m_wc = 0;
        end else begin
            if (!st_valid || st_w) m_wc = 0;
            else if (m_wc < MAXW) m_wc++;
            if (!m_busy && ld_w) begin
                m_busy = 1; m_killed = 0; m_pd = int'(ld_pd); m_rob = int'(ld_rob);
            end else if (m_busy) begin
                if (young) m_killed = 1;
                if (mem_rvalid) m_busy = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        ld_valid = 0; ld_addr = 0; ld_func3 = 0; ld_pd = 0; ld_rob = 0;
        st_valid = 0; st_addr = 0; st_data = 0; st_func3 = 0;
        rob_head = 0; mispredict = 0; mispredict_tag = 0;
        mem_rvalid = 0; mem_rdata = 0;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        m_busy = 0; m_killed = 0; m_pd = 0; m_rob = 0; m_wc = 0;
        tick(); tick();
        reset = 0;
        tick();

        // Basic load, data back two cycles after grant
        ld_valid = 1; ld_addr = 32'h40; ld_pd = 9; ld_rob = 3; ld_func3 = 3'd2;
        #2 chk("c1_grant", {31'b0, ld_ready}, 32'd1);
        tick();
        idle_inputs();
        tick();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        #2 chk("c1_data", ld_done_data, 32'hDEADBEEF);
        chk("c1_pd", {25'b0, ld_done_pd}, 32'd9);
        tick();
        idle_inputs();
        tick();

        // Store ages behind back-to-back loads to a different word
        st_valid = 1; st_addr = 32'h100; st_data = 32'hCAFE0001; st_func3 = 3'd2;
        ld_valid = 1; ld_addr = 32'h104; ld_pd = 5; ld_rob = 2;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid = m_busy; mem_rdata = 32'h1000 + i;
            tick();
        end
        idle_inputs();
        tick();

        // Same-word conflict: store first, then the load
        st_valid = 1; st_addr = 32'h80; st_data = 32'h12345678;
        ld_valid = 1; ld_addr = 32'h82; ld_pd = 7; ld_rob = 4;
        #2 chk("c3_store_first", {31'b0, st_ready}, 32'd1);
        tick();
        st_valid = 0;
        #2 chk("c3_load_next", {31'b0, ld_ready}, 32'd1);
        tick();
        idle_inputs(); mem_rvalid = 1; tick();
        idle_inputs(); tick();

        // Wrong-path load killed across the tag wrap, then an older load survives
        for (int k = 0; k < 2; k++) begin
            rob_head = 14;
            ld_valid = 1; ld_addr = 32'h200; ld_pd = 11; ld_rob = (k == 0) ? 5'd1 : 5'd14;
            tick();
            ld_valid = 0; mispredict = 1; mispredict_tag = 15;
            tick();
            mispredict = 0; mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
            #2 chk("c4_done", {31'b0, ld_done}, (k == 0) ? 32'd0 : 32'd1);
            tick();
            idle_inputs();
            #2 chk("c4_idle", {31'b0, busy}, 32'd0);
            tick();
        end

        // Load blocked by a coincident mispredict, granted the cycle after
        ld_valid = 1; ld_addr = 32'h300; mispredict = 1; mispredict_tag = 2;
        #2 chk("c5_blocked", {31'b0, mem_req}, 32'd0);
        tick();
        mispredict = 0;
        #2 chk("c5_granted", {31'b0, ld_ready}, 32'd1);
        tick();
        idle_inputs(); mem_rvalid = 1; tick();
        idle_inputs(); tick();

        // Reset while a load is in flight
        ld_valid = 1; ld_addr = 32'h400; ld_pd = 3; ld_rob = 6;
        tick();
        idle_inputs(); tick();
        reset = 1; tick();
        reset = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
        #2 chk("c6_no_done", {31'b0, ld_done}, 32'd0);
        tick();
        idle_inputs(); tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            ld_valid = ($urandom_range(0, 99) < 70);
            ld_addr = 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            ld_func3 = 3'($urandom_range(0, 7));
            ld_pd = PD_W'($urandom_range(0, 127));
            ld_rob = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
            st_valid = ($urandom_range(0, 99) < 50);
            st_addr = 32'h1000 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            st_data = $urandom;
            st_func3 = 3'($urandom_range(0, 7));
            rob_head = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
            mispredict = ($urandom_range(0, 99) < 15);
            mispredict_tag = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
            mem_rvalid = m_busy ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
            mem_rdata = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
